// File: rtl/cache_controller_if.sv
// Pipeline/memory bus of the direct-mapped cache controller.
// slave = the controller; master = the pipeline and memory side that drives it.
interface cache_controller_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic        stall;
  logic        hit;
  logic [3:0]  cacheIndex;
  logic        cacheWe;
  logic        cacheSrcSel;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic        memAck;

  modport slave (
    input  memRead, memWrite, addr, memAck,
    output stall, hit, cacheIndex, cacheWe, cacheSrcSel, memReq, memWe, memAddr
  );

  modport master (
    output memRead, memWrite, addr, memAck,
    input  stall, hit, cacheIndex, cacheWe, cacheSrcSel, memReq, memWe, memAddr
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped 16 x 1-word write-through, no-write-allocate cache controller.
// Define CACHE_STATS_EN to add saturating hitCount/missCount outputs.
module cache_controller (
  input  logic              clk,
  input  logic              rstN,
  cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  typedef enum logic [1:0] {IDLE, RD_REQ, FILL, WR_REQ} state_t;

  state_t      state_q, state_d;
  logic [15:0] valid_q;
  logic [25:0] tag_q [16];
  logic        wr_hit_q, wr_hit_d;

  logic [3:0]  idx;
  logic [25:0] tag_in;
  logic        lookup;
  logic        unused_addr_bits;

  logic stall, hit, cache_we, cache_src_sel, mem_req, mem_we;

  assign idx              = bus.addr[5:2];
  assign tag_in           = bus.addr[31:6];
  assign lookup           = valid_q[idx] && (tag_q[idx] == tag_in);
  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    state_d       = state_q;
    wr_hit_d      = wr_hit_q;
    stall         = 1'b0;
    hit           = 1'b0;
    cache_we      = 1'b0;
    cache_src_sel = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    // Outputs are forced quiet while reset is held, even with a request pending.
    if (rstN) begin
      unique case (state_q)
        IDLE: begin
          if (bus.memWrite) begin
            hit      = lookup;
            stall    = 1'b1;
            wr_hit_d = lookup;
            state_d  = WR_REQ;
          end else if (bus.memRead) begin
            hit = lookup;
            if (!lookup) begin
              stall   = 1'b1;
              state_d = RD_REQ;
            end
          end
        end
        RD_REQ: begin
          mem_req = 1'b1;
          stall   = 1'b1;
          if (bus.memAck) state_d = FILL;
        end
        FILL: begin
          cache_we      = 1'b1;
          cache_src_sel = 1'b1;
          stall         = 1'b1;
          state_d       = IDLE;
        end
        WR_REQ: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          stall   = !bus.memAck;
          if (bus.memAck) begin
            cache_we = wr_hit_q;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      valid_q  <= 16'h0000;
      wr_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_hit_q <= wr_hit_d;
      if (state_q == FILL) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstN && state_q == FILL) tag_q[idx] <= tag_in;
  end

  assign bus.stall       = stall;
  assign bus.hit         = hit;
  assign bus.cacheIndex  = idx;
  assign bus.cacheWe     = cache_we;
  assign bus.cacheSrcSel = cache_src_sel;
  assign bus.memReq      = mem_req;
  assign bus.memWe       = mem_we;
  assign bus.memAddr     = {bus.addr[31:2], 2'b00};

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        refill_q;
  logic        new_access;

  // The cycle after FILL re-presents the same load; it must not count again.
  assign new_access = rstN && state_q == IDLE && (bus.memRead || bus.memWrite) && !refill_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= (state_q == FILL);
      if (new_access && lookup && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (new_access && !lookup && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: reset, directed table, reset abort, random traffic.
module tb_cache_controller;

  logic clk;
  logic rstN;
  cache_controller_if bus();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller dut (
    .clk   (clk),
    .rstN  (rstN),
    .bus   (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hitCount  (hit_count),
    .missCount (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Observations from one access
  int   r_stall, r_req, r_we, r_fill, r_cpu, r_bad;
  logic r_first, r_final;

  // Reference model: contents of the cache and access tallies
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  int          m_hits, m_miss;

  function automatic logic model_hit(logic [31:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  function automatic void model_update(logic rd, logic wr, logic [31:0] a);
    logic h;
    h = model_hit(a);
    if (rd || wr) begin
      if (h) m_hits++;
      else   m_miss++;
    end
    if (rd && !wr && !h) begin
      m_valid[a[5:2]] = 1'b1;
      m_tag[a[5:2]]   = a[31:6];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endfunction

  // Called #1 after a rising edge; returns #1 after the rising edge that ends the access.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input int d);
    int  reqcnt;
    int  cyc;
    bit  done;
    bus.memRead  = rd;
    bus.memWrite = wr;
    bus.addr     = a;
    bus.memAck   = 1'b0;
    reqcnt = 0; cyc = 0; done = 0;
    r_stall = 0; r_req = 0; r_we = 0; r_fill = 0; r_cpu = 0; r_bad = 0;
    r_first = 1'b0; r_final = 1'b0;
    while (!done) begin
      #1;
      if (bus.memReq) begin
        reqcnt++;
        if (reqcnt == d + 1) bus.memAck = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) r_first = bus.hit;
      if (bus.stall) r_stall++;
      if (bus.memReq) r_req++;
      if (bus.memReq && bus.memWe) r_we++;
      if (bus.cacheWe && bus.cacheSrcSel) r_fill++;
      if (bus.cacheWe && !bus.cacheSrcSel) r_cpu++;
      if (bus.cacheIndex != a[5:2]) r_bad++;
      if (bus.memReq && bus.memAddr != {a[31:2], 2'b00}) r_bad++;
      if (!bus.stall) begin
        done    = 1;
        r_final = bus.hit;
      end
      cyc++;
      if (cyc >= 60 && !done) begin
        check("access_timeout", 1, 0);
        done = 1;
      end
      @(posedge clk);
      #1;
      bus.memAck = 1'b0;
    end
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  task automatic run_check(input logic rd, input logic wr, input logic [31:0] a, input int d);
    logic h;
    int   e_stall, e_req, e_we, e_fill, e_cpu;
    logic e_first, e_final;
    h = model_hit(a);
    e_stall = 0; e_req = 0; e_we = 0; e_fill = 0; e_cpu = 0; e_first = 1'b0; e_final = 1'b0;
    if (wr) begin
      e_stall = d + 1; e_req = d + 1; e_we = d + 1; e_cpu = h ? 1 : 0; e_first = h;
    end else if (rd) begin
      e_first = h; e_final = 1'b1;
      if (!h) begin
        e_stall = d + 3; e_req = d + 1; e_fill = 1;
      end
    end
    do_access(rd, wr, a, d);
    check("rnd_stall_cycles", r_stall, e_stall);
    check("rnd_memreq_cycles", r_req, e_req);
    check("rnd_memwe_cycles", r_we, e_we);
    check("rnd_fill_writes", r_fill, e_fill);
    check("rnd_store_writes", r_cpu, e_cpu);
    check("rnd_first_hit", int'(r_first), int'(e_first));
    check("rnd_final_hit", int'(r_final), int'(e_final));
    check("rnd_addr_outputs", r_bad, 0);
    model_update(rd, wr, a);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    int          d;
    int          stall_n;
    logic        first_hit;
    logic        final_hit;
    int          req_n;
    int          we_n;
    int          fill_n;
    int          cpu_n;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h40, 1, 4, 1'b0, 1'b1, 2, 0, 1, 0}; // cold miss, ack in cycle 3
    tbl[1] = '{1'b1, 1'b0, 32'h40, 0, 0, 1'b1, 1'b1, 0, 0, 0, 0}; // read hit
    tbl[2] = '{1'b1, 1'b0, 32'h80, 0, 3, 1'b0, 1'b1, 1, 0, 1, 0}; // conflict miss on line 0
    tbl[3] = '{1'b1, 1'b0, 32'h40, 2, 5, 1'b0, 1'b1, 3, 0, 1, 0}; // refill line 0 again
    tbl[4] = '{1'b0, 1'b1, 32'h40, 2, 3, 1'b1, 1'b0, 3, 3, 0, 1}; // store hit
    tbl[5] = '{1'b0, 1'b1, 32'h44, 1, 2, 1'b0, 1'b0, 2, 2, 0, 0}; // store miss, no allocate
    tbl[6] = '{1'b1, 1'b0, 32'h44, 0, 3, 1'b0, 1'b1, 1, 0, 1, 0}; // line 1 still invalid
    tbl[7] = '{1'b1, 1'b1, 32'h40, 0, 1, 1'b1, 1'b0, 1, 1, 0, 1}; // store wins over load
    tbl[8] = '{1'b0, 1'b0, 32'h40, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0}; // no request

    bus.memRead = 1'b1; bus.memWrite = 1'b0; bus.addr = 32'h40; bus.memAck = 1'b0;
    rstN = 1'b0;
    model_reset();
    #12;
    check("rst_stall", int'(bus.stall), 0);
    check("rst_hit", int'(bus.hit), 0);
    check("rst_memreq", int'(bus.memReq), 0);
    check("rst_memwe", int'(bus.memWe), 0);
    check("rst_cachewe", int'(bus.cacheWe), 0);
    check("rst_srcsel", int'(bus.cacheSrcSel), 0);
`ifdef CACHE_STATS_EN
    check("rst_hitcount", int'(hit_count), 0);
    check("rst_misscount", int'(miss_count), 0);
`endif
    bus.memRead = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      model_update(tbl[i].rd, tbl[i].wr, tbl[i].a);
      check($sformatf("vec%0d_stall_cycles", i), r_stall, tbl[i].stall_n);
      check($sformatf("vec%0d_first_hit", i), int'(r_first), int'(tbl[i].first_hit));
      check($sformatf("vec%0d_final_hit", i), int'(r_final), int'(tbl[i].final_hit));
      check($sformatf("vec%0d_memreq_cycles", i), r_req, tbl[i].req_n);
      check($sformatf("vec%0d_memwe_cycles", i), r_we, tbl[i].we_n);
      check($sformatf("vec%0d_fill_writes", i), r_fill, tbl[i].fill_n);
      check($sformatf("vec%0d_store_writes", i), r_cpu, tbl[i].cpu_n);
      check($sformatf("vec%0d_addr_outputs", i), r_bad, 0);
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        check("stats_hitcount_after_two", int'(hit_count), 1);
        check("stats_misscount_after_two", int'(miss_count), 1);
      end
`endif
    end

    // A stray memAck with no transfer in flight must change nothing.
    bus.memAck = 1'b1;
    @(negedge clk);
    check("stray_ack_stall", int'(bus.stall), 0);
    check("stray_ack_memreq", int'(bus.memReq), 0);
    check("stray_ack_cachewe", int'(bus.cacheWe), 0);
    @(posedge clk);
    #1;
    bus.memAck = 1'b0;
    run_check(1'b1, 1'b0, 32'h40, 0);

    // Reset in the middle of a read miss aborts the fill.
    bus.addr = 32'h100; bus.memRead = 1'b1;
    @(negedge clk);
    check("abort_idle_stall", int'(bus.stall), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_rdreq_memreq", int'(bus.memReq), 1);
    #1;
    rstN = 1'b0;
    #1;
    check("abort_memreq_drop", int'(bus.memReq), 0);
    check("abort_stall_drop", int'(bus.stall), 0);
    bus.memAck = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cachewe", int'(bus.cacheWe), 0);
    bus.memAck = 1'b0;
    bus.memRead = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    run_check(1'b1, 1'b0, 32'h40, 0);
    check("abort_then_lw_missed", r_fill, 1);

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      run_check(kind[0], kind[1], a, $urandom_range(0, 3));
    end

`ifdef CACHE_STATS_EN
    check("stats_hitcount_random", int'(hit_count), m_hits);
    check("stats_misscount_random", int'(miss_count), m_miss);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
